prog_sequencer: RTL and testbench

Parametrised fetch/launch sequencer for the core: owns the program counter, the Start/Ack run handshake and the cycle counter. It generalises the single-program start gating to NPROG selectable program entry points, configurable PC width, signed relative and absolute branching, and a cycle-budget timeout. It sits between the testbench handshake pins and instruction ROM, decoder and ALU flags.

---
 rtl/prog_sequencer.sv | 146 ++++++++++++++
 tb/tb_prog_sequencer.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_sequencer.sv
// prog_sequencer
// Fetch/launch sequencer. It owns the program counter, the Start/Ack run
// handshake and the per-run cycle counter. NPROG program entry points can be
// selected. Branches can be absolute or signed-relative, and an optional
// cycle budget can end a run early.
//
// Ports:
//   Clk         system clock, rising edge
//   Reset       synchronous, active-high; returns everything to IDLE
//   Start       launch request (level); while high the entry address is reloaded
//   ProgSel     program index, sampled while Start is high
//   BranchAbsEn unconditional absolute jump to Target (RUN only)
//   BranchRelEn relative branch by signed Target, taken when Flag=1 (RUN only)
//   Flag        ALU condition flag
//   Target      absolute address or two's-complement offset
//   HaltReq     decoder "done" instruction (RUN only)
//   ProgCtr     current fetch address
//   Running     high only in RUN
//   Ack         high in DONE (run complete)
//   Timeout     last run ended by budget expiry
//   CycleCount  RUN cycles of the current/last run, saturating
module prog_sequencer #(
    parameter int                 PW         = 10,
    parameter int                 TW         = 10,
    parameter int                 NPROG      = 4,
    parameter logic [NPROG*PW-1:0] PROG_BASE = '0,
    parameter int                 CW         = 16,
    parameter int                 MAX_CYCLES = 0,
    localparam int                SW         = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic [SW-1:0] ProgSel,
    input  logic          BranchAbsEn,
    input  logic          BranchRelEn,
    input  logic          Flag,
    input  logic [TW-1:0] Target,
    input  logic          HaltReq,
    output logic [PW-1:0] ProgCtr,
    output logic          Running,
    output logic          Ack,
    output logic          Timeout,
    output logic [CW-1:0] CycleCount
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // An out-of-range selector (NPROG not a power of two) falls back to entry 0.
    function automatic logic [PW-1:0] entry_addr(input logic [SW-1:0] sel);
        if (int'(sel) < NPROG)
            return PROG_BASE[int'(sel)*PW +: PW];
        else
            return PROG_BASE[0 +: PW];
    endfunction

    // Sign-extend the offset to PC width; the add wraps modulo 2^PW.
    function automatic logic [PW-1:0] rel_target(input logic [PW-1:0] pc,
                                                 input logic [TW-1:0] off);
        logic signed [TW-1:0] off_s;
        logic signed [PW-1:0] off_x;
        off_s = $signed(off);
        off_x = PW'(off_s);
        return pc + $unsigned(off_x);
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    logic budget_hit;
    assign budget_hit = (MAX_CYCLES != 0) && (CycleCount == CW'(MAX_CYCLES - 1));

    assign Running = (state == RUN);
    assign Ack     = (state == DONE);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ProgCtr    <= '0;
            CycleCount <= '0;
            Timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state      <= ARMED;
                        ProgCtr    <= entry_addr(ProgSel);
                        CycleCount <= '0;
                        Timeout    <= 1'b0;
                    end
                end
                ARMED: begin
                    // Keep reloading while Start is held so the last ProgSel wins.
                    if (Start) begin
                        ProgCtr    <= entry_addr(ProgSel);
                        CycleCount <= '0;
                        Timeout    <= 1'b0;
                    end else begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (Start) begin
                        // Abort and relaunch; the old count is discarded.
                        state      <= ARMED;
                        ProgCtr    <= entry_addr(ProgSel);
                        CycleCount <= '0;
                        Timeout    <= 1'b0;
                    end else begin
                        CycleCount <= sat_inc(CycleCount);
                        if (HaltReq) begin
                            state <= DONE;
                        end else if (budget_hit) begin
                            state   <= DONE;
                            Timeout <= 1'b1;
                        end else if (BranchAbsEn) begin
                            ProgCtr <= PW'(Target);
                        end else if (BranchRelEn && Flag) begin
                            ProgCtr <= rel_target(ProgCtr, Target);
                        end else begin
                            ProgCtr <= ProgCtr + PW'(1);
                        end
                    end
                end
                DONE: begin
                    if (Start) begin
                        state      <= ARMED;
                        ProgCtr    <= entry_addr(ProgSel);
                        CycleCount <= '0;
                        Timeout    <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// tb_prog_sequencer
// Drives three prog_sequencer instances from shared stimulus:
//   a: CW=16, no budget; b: CW=16, MAX_CYCLES=8; c: CW=3, no budget.
// Each instance is compared every cycle against a behavioural model. Named
// directed checks cover the launch, branch, wrap, halt, timeout,
// saturation and abort scenarios. A randomized phase follows them.
module tb_prog_sequencer;

    localparam int PW = 10;
    localparam int TW = 10;
    localparam int NPROG = 4;
    localparam logic [NPROG*PW-1:0] BASE = {10'd700, 10'd100, 10'd300, 10'd5};

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic [1:0]    ProgSel = '0;
    logic          BranchAbsEn = 1'b0;
    logic          BranchRelEn = 1'b0;
    logic          Flag = 1'b0;
    logic [TW-1:0] Target = '0;
    logic          HaltReq = 1'b0;

    logic [PW-1:0] pc_a, pc_b, pc_c;
    logic          run_a, run_b, run_c;
    logic          ack_a, ack_b, ack_c;
    logic          to_a, to_b, to_c;
    logic [15:0]   cc_a, cc_b;
    logic [2:0]    cc_c;

    always #5 Clk = ~Clk;

    prog_sequencer #(.PW(PW), .TW(TW), .NPROG(NPROG), .PROG_BASE(BASE), .CW(16), .MAX_CYCLES(0)) dut_a (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .Flag(Flag),
        .Target(Target), .HaltReq(HaltReq),
        .ProgCtr(pc_a), .Running(run_a), .Ack(ack_a), .Timeout(to_a), .CycleCount(cc_a));

    prog_sequencer #(.PW(PW), .TW(TW), .NPROG(NPROG), .PROG_BASE(BASE), .CW(16), .MAX_CYCLES(8)) dut_b (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .Flag(Flag),
        .Target(Target), .HaltReq(HaltReq),
        .ProgCtr(pc_b), .Running(run_b), .Ack(ack_b), .Timeout(to_b), .CycleCount(cc_b));

    prog_sequencer #(.PW(PW), .TW(TW), .NPROG(NPROG), .PROG_BASE(BASE), .CW(3), .MAX_CYCLES(0)) dut_c (
        .Clk(Clk), .Reset(Reset), .Start(Start), .ProgSel(ProgSel),
        .BranchAbsEn(BranchAbsEn), .BranchRelEn(BranchRelEn), .Flag(Flag),
        .Target(Target), .HaltReq(HaltReq),
        .ProgCtr(pc_c), .Running(run_c), .Ack(ack_c), .Timeout(to_c), .CycleCount(cc_c));

    // Behavioural model: phase 0 idle, 1 armed, 2 running, 3 done.
    typedef struct {
        int st;
        int pc;
        int cc;
        bit to;
    } mdl_t;

    mdl_t ma, mb, mc;
    int   base_tbl[4] = '{5, 300, 100, 700};
    int   errors = 0;
    int   checks = 0;

    function automatic mdl_t step(mdl_t m, int maxc, int ccmax);
        mdl_t n;
        int   off;
        n = m;
        if (Reset) begin
            n.st = 0; n.pc = 0; n.cc = 0; n.to = 0;
            return n;
        end
        if (Start && m.st != 2 || Start && m.st == 2) begin
            // Start from any phase (re)arms with the selected entry address.
            if (m.st == 1 && !Start) begin
                n.st = 2;
            end else begin
                n.st = 1; n.pc = base_tbl[ProgSel]; n.cc = 0; n.to = 0;
            end
            return n;
        end
        if (m.st == 1) begin
            n.st = 2;
        end else if (m.st == 2) begin
            n.cc = (m.cc + 1 > ccmax) ? ccmax : m.cc + 1;
            off  = (int'(Target) >= 512) ? int'(Target) - 1024 : int'(Target);
            if (HaltReq)                          n.st = 3;
            else if (maxc != 0 && m.cc == maxc-1) begin n.st = 3; n.to = 1; end
            else if (BranchAbsEn)                 n.pc = int'(Target);
            else if (BranchRelEn && Flag)         n.pc = ((m.pc + off) % 1024 + 1024) % 1024;
            else                                  n.pc = (m.pc + 1) % 1024;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cmp_all();
        check("a.pc",  32'(pc_a),  32'(ma.pc));
        check("a.run", 32'(run_a), 32'(ma.st == 2));
        check("a.ack", 32'(ack_a), 32'(ma.st == 3));
        check("a.to",  32'(to_a),  32'(ma.to));
        check("a.cc",  32'(cc_a),  32'(ma.cc));
        check("b.pc",  32'(pc_b),  32'(mb.pc));
        check("b.run", 32'(run_b), 32'(mb.st == 2));
        check("b.ack", 32'(ack_b), 32'(mb.st == 3));
        check("b.to",  32'(to_b),  32'(mb.to));
        check("b.cc",  32'(cc_b),  32'(mb.cc));
        check("c.pc",  32'(pc_c),  32'(mc.pc));
        check("c.run", 32'(run_c), 32'(mc.st == 2));
        check("c.ack", 32'(ack_c), 32'(mc.st == 3));
        check("c.to",  32'(to_c),  32'(mc.to));
        check("c.cc",  32'(cc_c),  32'(mc.cc));
    endtask

    // One clock: models advance on the edge, outputs compared 1 time unit later.
    task automatic cyc();
        @(posedge Clk);
        ma = step(ma, 0, 65535);
        mb = step(mb, 8, 65535);
        mc = step(mc, 0, 7);
        #1;
        cmp_all();
    endtask

    task automatic clear_branch();
        BranchAbsEn = 1'b0; BranchRelEn = 1'b0; Flag = 1'b0; Target = '0;
    endtask

    task automatic jump_abs(input int t);
        BranchAbsEn = 1'b1; Target = TW'(t);
        cyc();
        BranchAbsEn = 1'b0;
    endtask

    initial begin
        ma = '{0, 0, 0, 0}; mb = '{0, 0, 0, 0}; mc = '{0, 0, 0, 0};

        // Reset for two cycles.
        Reset = 1'b1;
        repeat (2) cyc();
        check("rst_pc", 32'(pc_a), 0);
        check("rst_run", 32'(run_a), 0);
        check("rst_ack", 32'(ack_a), 0);
        check("rst_cc", 32'(cc_a), 0);
        Reset = 1'b0;

        // Launch program 2 (entry 100) with Start held three cycles.
        Start = 1'b1; ProgSel = 2'd2;
        cyc();
        check("armed_pc", 32'(pc_a), 100);
        check("armed_run", 32'(run_a), 0);
        repeat (2) cyc();
        Start = 1'b0;
        cyc();
        check("run_pc0", 32'(pc_a), 100);
        check("run_on", 32'(run_a), 1);
        cyc();
        check("run_pc1", 32'(pc_a), 101);
        cyc();
        check("run_pc2", 32'(pc_a), 102);
        repeat (7) cyc();
        check("budget_ack", 32'(ack_b), 1);
        check("budget_to", 32'(to_b), 1);
        check("budget_cc", 32'(cc_b), 8);
        check("sat_cc", 32'(cc_c), 7);
        check("sat_run", 32'(run_c), 1);
        check("nobudget_cc", 32'(cc_a), 9);

        // Branching.
        jump_abs(50);
        check("abs50", 32'(pc_a), 50);
        BranchRelEn = 1'b1; Flag = 1'b1; Target = 10'h3FE;
        cyc();
        check("rel_m2", 32'(pc_a), 48);
        clear_branch();
        jump_abs(50);
        BranchRelEn = 1'b1; Flag = 1'b0; Target = 10'h3FE;
        cyc();
        check("rel_nflag", 32'(pc_a), 51);
        BranchAbsEn = 1'b1; BranchRelEn = 1'b1; Flag = 1'b1; Target = 10'd7;
        cyc();
        check("abs_wins", 32'(pc_a), 7);
        clear_branch();
        jump_abs(1023);
        cyc();
        check("pc_wrap", 32'(pc_a), 0);
        jump_abs(1022);
        BranchRelEn = 1'b1; Flag = 1'b1; Target = 10'd5;
        cyc();
        check("rel_wrap", 32'(pc_a), 3);
        clear_branch();

        // Halt after 20 RUN cycles, then relaunch.
        Start = 1'b1; ProgSel = 2'd0;
        cyc();
        Start = 1'b0;
        cyc();
        check("p0_entry", 32'(pc_a), 5);
        repeat (19) cyc();
        HaltReq = 1'b1;
        cyc();
        HaltReq = 1'b0;
        check("halt_ack", 32'(ack_a), 1);
        check("halt_cc", 32'(cc_a), 20);
        check("halt_to", 32'(to_a), 0);
        check("halt_run", 32'(run_a), 0);
        Start = 1'b1;
        cyc();
        check("rearm_ack", 32'(ack_a), 0);
        check("rearm_cc", 32'(cc_a), 0);
        check("rearm_to_b", 32'(to_b), 0);
        Start = 1'b0;
        cyc();

        // Reset mid-run at PC 37.
        jump_abs(37);
        check("pc37", 32'(pc_a), 37);
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("abort_pc", 32'(pc_a), 0);
        check("abort_run", 32'(run_a), 0);
        check("abort_ack", 32'(ack_a), 0);
        repeat (5) cyc();
        check("idle_ack", 32'(ack_a), 0);

        // Start mid-run relaunches from a new entry.
        Start = 1'b1; ProgSel = 2'd2;
        cyc();
        Start = 1'b0;
        repeat (4) cyc();
        Start = 1'b1; ProgSel = 2'd1;
        cyc();
        check("relaunch_pc", 32'(pc_a), 300);
        check("relaunch_run", 32'(run_a), 0);
        check("relaunch_cc", 32'(cc_a), 0);
        Start = 1'b0;
        cyc();
        check("relaunch_go", 32'(run_a), 1);

        // Randomized phase.
        for (int i = 0; i < 3000; i++) begin
            Reset       = ($urandom_range(0, 299) == 0);
            Start       = ($urandom_range(0, 19) == 0);
            ProgSel     = 2'($urandom_range(0, 3));
            BranchAbsEn = ($urandom_range(0, 7) == 0);
            BranchRelEn = ($urandom_range(0, 3) == 0);
            Flag        = 1'($urandom_range(0, 1));
            Target      = TW'($urandom);
            HaltReq     = ($urandom_range(0, 39) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
